// File: rtl/sev_seg_scan.sv
// sev_seg_scan
//   Multi-digit scan driver feeding a combinational seven-segment decoder.
//   A packed hex value arrives over valid/ready and is double-buffered; the
//   digits are then time-multiplexed onto one 4-bit nibble output with
//   active-low digit enables, dead time between digits and optional
//   leading-zero blanking. New values take effect only at frame boundaries.
//
// Parameters
//   DIGITS   number of digits scanned (2..8), digit 0 least significant
//   PRESCALE clock cycles each digit is lit (>= 2)
//   DEAD     clock cycles with all digits off between digits (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   load_valid  load_data valid this cycle
//   load_ready  block can accept load_data
//   load_data   packed nibbles, bits [4i+3:4i] are digit i
//   blank_lz    leading-zero blanking enable, sampled every cycle
//   nibble      current digit value to the decoder (bit 0 -> A20)
//   dig_en_n    active-low one-hot digit enable, all ones = dark
module sev_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1024,
  parameter int DEAD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     dig_en_n
);

  localparam int CNT_MAX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DIG_W   = $clog2(DIGITS);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [DIG_W-1:0]      digit_r, digit_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s;
  logic [4*DIGITS-1:0]   active_r, active_next_s;
  logic [4*DIGITS-1:0]   pending_r, pending_next_s;
  logic                  pend_full_r, pend_full_next_s;
  logic [3:0]            nibble_r, nibble_next_s;
  logic [DIGITS-1:0]     dig_en_n_r, dig_en_n_next_s;
  logic                  load_ready_r, load_ready_next_s;
  logic                  accept_s;
  logic                  show_end_s;
  logic                  dead_end_s;
  logic                  last_digit_s;

  // Select nibble 'dig' out of a packed value.
  function automatic logic [3:0] nibble_sel(input logic [4*DIGITS-1:0] value,
                                            input logic [DIG_W-1:0]    dig);
    logic [3:0] res;
    res = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      res = res | (value[4*i +: 4] & {4{DIG_W'(i) == dig}});
    end
    return res;
  endfunction

  // Digit i>0 is blanked when it and every more significant nibble are zero.
  function automatic logic is_blanked(input logic [4*DIGITS-1:0] value,
                                      input logic [DIG_W-1:0]    dig,
                                      input logic                lz_en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      upper_zero = upper_zero &
                   ~((DIG_W'(i) >= dig) && (value[4*i +: 4] != 4'h0));
    end
    return lz_en && (dig != {DIG_W{1'b0}}) && upper_zero;
  endfunction

  // Active-low one-hot enable for digit 'dig'.
  function automatic logic [DIGITS-1:0] dig_onehot_n(input logic [DIG_W-1:0] dig);
    logic [DIGITS-1:0] res;
    res = {DIGITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      res[i] = ~(DIG_W'(i) == dig);
    end
    return res;
  endfunction

  assign accept_s     = load_valid & load_ready_r;
  assign show_end_s   = (cnt_r == CNT_W'(PRESCALE - 1));
  assign dead_end_s   = (cnt_r == CNT_W'(DEAD - 1));
  assign last_digit_s = (digit_r == DIG_W'(DIGITS - 1));

  // Next-state, buffer and registered-output computation.
  always_comb begin
    state_next_s      = state_r;
    digit_next_s      = digit_r;
    cnt_next_s        = cnt_r;
    active_next_s     = active_r;
    pending_next_s    = pending_r;
    pend_full_next_s  = pend_full_r;
    nibble_next_s     = nibble_r;
    dig_en_n_next_s   = {DIGITS{1'b1}};
    load_ready_next_s = 1'b1;

    case (state_r)
      ST_OFF: begin
        if (accept_s) begin
          active_next_s = load_data;
          state_next_s  = ST_SHOW;
          digit_next_s  = {DIG_W{1'b0}};
          cnt_next_s    = {CNT_W{1'b0}};
        end else begin
          state_next_s  = ST_OFF;
        end
      end
      ST_SHOW: begin
        if (show_end_s) begin
          state_next_s = ST_DEAD;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
        if (accept_s) begin
          pending_next_s   = load_data;
          pend_full_next_s = 1'b1;
        end else begin
          pend_full_next_s = pend_full_r;
        end
      end
      ST_DEAD: begin
        if (dead_end_s) begin
          state_next_s = ST_SHOW;
          cnt_next_s   = {CNT_W{1'b0}};
          digit_next_s = last_digit_s ? {DIG_W{1'b0}} : digit_r + DIG_W'(1);
        end else begin
          cnt_next_s   = cnt_r + CNT_W'(1);
        end
        // On the frame-wrap edge a full shadow wins; otherwise a load
        // arriving on that very edge is applied directly.
        if (dead_end_s && last_digit_s) begin
          if (pend_full_r) begin
            active_next_s    = pending_r;
            pend_full_next_s = 1'b0;
          end else if (accept_s) begin
            active_next_s    = load_data;
          end else begin
            active_next_s    = active_r;
          end
        end else if (accept_s) begin
          pending_next_s   = load_data;
          pend_full_next_s = 1'b1;
        end else begin
          pend_full_next_s = pend_full_r;
        end
      end
      default: begin
        state_next_s     = ST_OFF;
        pend_full_next_s = 1'b0;
      end
    endcase

    // Outputs are derived from next-state values and registered, so the
    // ports never see a combinational path from any input.
    case (state_next_s)
      ST_SHOW: begin
        nibble_next_s = nibble_sel(active_next_s, digit_next_s);
        if (is_blanked(active_next_s, digit_next_s, blank_lz)) begin
          dig_en_n_next_s = {DIGITS{1'b1}};
        end else begin
          dig_en_n_next_s = dig_onehot_n(digit_next_s);
        end
      end
      ST_DEAD: begin
        nibble_next_s   = nibble_r;
        dig_en_n_next_s = {DIGITS{1'b1}};
      end
      default: begin
        nibble_next_s   = 4'h0;
        dig_en_n_next_s = {DIGITS{1'b1}};
      end
    endcase
    load_ready_next_s = (state_next_s == ST_OFF) ? 1'b1 : ~pend_full_next_s;
  end

  // State, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_OFF;
      digit_r      <= {DIG_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      active_r     <= {(4*DIGITS){1'b0}};
      pending_r    <= {(4*DIGITS){1'b0}};
      pend_full_r  <= 1'b0;
      nibble_r     <= 4'h0;
      dig_en_n_r   <= {DIGITS{1'b1}};
      load_ready_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      digit_r      <= digit_next_s;
      cnt_r        <= cnt_next_s;
      active_r     <= active_next_s;
      pending_r    <= pending_next_s;
      pend_full_r  <= pend_full_next_s;
      nibble_r     <= nibble_next_s;
      dig_en_n_r   <= dig_en_n_next_s;
      load_ready_r <= load_ready_next_s;
    end
  end

  assign nibble     = nibble_r;
  assign dig_en_n   = dig_en_n_r;
  assign load_ready = load_ready_r;

endmodule

// File: doc/sev_seg_scan.md
# sev_seg_scan

Multi-digit scan driver sitting directly upstream of the combinational seven-segment decoder. It accepts a packed hex value over a valid/ready handshake and double-buffers it. It then time-multiplexes the digits onto the decoder's single 4-bit input while driving active-low digit enables, with dead time between digits and optional leading-zero blanking. New values are applied only at frame boundaries, so a displayed number never tears.

## Interface
- DIGITS, 4, number of digits scanned (2..8); digit 0 is least significant.
- PRESCALE, 1024, clock cycles each digit is lit (≥2).
- DEAD, 16, clock cycles with all digits off between digits (≥1).

One clock; reset is synchronous and active-low.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  block can accept load_data; transfer occurs on an edge where load_valid & load_ready.
- load_data  in  4*DIGITS  packed nibbles; bits [4i+3:4i] are digit i.
- blank_lz  in  1  enables leading-zero blanking; sampled every cycle.
- nibble  out  4  value of the current digit to the decoder; bit 0 (LSB) drives decoder input A20, bit 3 drives A23.
- dig_en_n  out  DIGITS  active-low one-hot digit enable; all ones means display dark.

## Operation
- Registers:
  - active (displayed value);
  - pending plus pend_full (shadow buffer);
  - state, one of OFF, SHOW, DEAD;
  - digit index (0..DIGITS-1);
  - cnt.
- Outputs are functions of registers only; there is no combinational path from any input to any output.
- OFF (reset state): dig_en_n all ones, nibble 0, load_ready 1.
  - On an accepting edge: active←load_data, state←SHOW, digit←0, cnt←0.
- SHOW: nibble = active[4·digit+3:4·digit].
  - dig_en_n has bit digit low, unless that digit is blanked.
  - cnt counts 0..PRESCALE-1; at PRESCALE-1: state←DEAD, cnt←0.
- DEAD: dig_en_n all ones; nibble holds the previous value.
  - cnt counts 0..DEAD-1; at DEAD-1: state←SHOW, cnt←0, digit←digit+1, wrapping DIGITS-1→0.
- Blanking: digit i>0 is blanked when blank_lz=1 and nibbles i..DIGITS-1 of active are all zero. Digit 0 is never blanked, so value 0 shows a single "0". A blanked digit still consumes its full SHOW slot.
- Load path while in SHOW/DEAD:
  - load_ready = !pend_full.
  - An accepting edge sets pending←load_data and pend_full←1.
- Frame-wrap edge (DEAD, digit DIGITS-1, cnt DEAD-1):
  - If pend_full: active←pending, pend_full←0.
  - Else, if the same edge accepts a load: active←load_data directly (bypass) and pending is untouched.
- Upstream holding load_valid while load_ready=0 stalls; load_data is ignored until ready.
- Reset mid-operation: rst_n low at any edge returns all registers to reset values. This discards pending and active, and the display goes dark on the next cycle.

## Timing
- Reset values: dig_en_n all ones, nibble 4'h0, load_ready 1, state OFF, pend_full 0, active 0.
- Digit slot = PRESCALE+DEAD cycles; frame = DIGITS·(PRESCALE+DEAD) cycles.
- Accept in OFF at edge t: digit 0 is lit from cycle t+1.
- Accept in SHOW/DEAD at edge t: load_ready is 0 from cycle t+1 until the frame-wrap edge. The new value is shown and load_ready returns to 1 from the cycle after that edge.
- Worst-case apply latency: one frame plus one cycle.
- Between consecutive lit digits, all digits are off for exactly DEAD cycles; two enables are never low together.

## Test plan
Benches use DIGITS=4, PRESCALE=4, DEAD=2 (frame 24 cycles).

- **Reset and first load:** after reset, dig_en_n=1111, nibble=0, load_ready=1. Load 16'h1234 → next cycle dig_en_n=1110, nibble=4 for 4 cycles, then 1111 for 2 cycles, then 1101 with nibble=3, and so on through 2 and 1 at 0111.
- **Double buffer:** mid-frame, load 16'hABCD → load_ready=0 next cycle and the display continues 1234. At the wrap edge nibble=D on 1110, and load_ready=1 the cycle after.
- **Stall:** load_valid held with 16'h5555 while load_ready=0 → no overwrite of pending; accepted once ready returns; applied at the following wrap.
- **Leading-zero blanking:** blank_lz=1 with value 16'h0040 → only digits 0 and 1 are lit (nibbles 0 and 4); digits 2 and 3 stay dark for their full slots. Value 16'h0000 → only digit 0 is lit, showing 0. With blank_lz=0, all four digits are lit.
- **Wrap-edge bypass:** with pend_full=0, load 16'h0F0F exactly on the wrap edge → nibble=F on digit 0 next cycle; load_ready stays 1.
- **Mid-operation reset:** assert rst_n=0 for one edge during SHOW with pend_full=1 → dig_en_n=1111, load_ready=1, state OFF. No digit lights until a new load, and the old pending value is never shown.
